vme_cmd_executor: RTL and testbench
===================================

Name: vme_cmd_executor

Overview:
- Consumer side of the simulation command-file handshake.
- Pulls one command per transaction (vme_cmd_rd, then start/vme_cmd_reg/vme_dat_reg_in) and runs it as an A24/D16 VME master cycle toward the ODMB VME slave logic.
- Returns read data and completion through vme_dat_reg_out/vme_dat_wr, so the command file can be replayed against RTL without a physical crate.
- Synthesizable; also usable as an on-board command sequencer.

Parameters:
- ADDR_SETUP, 2, clocks AS_N is held low before DS_N asserts.
- DTACK_TIMEOUT, 255, clocks to wait for DTACK edges before aborting (8-bit counter).
- POLL_GAP, 4, idle clocks between vme_cmd_rd pulses after a no-op command.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- vme_cmd_rd  out  1  one-cycle request for next command
- start  in  1  command valid flag
- vme_cmd_reg  in  32  [25]=read(1)/write(0), [23:0]=A24 byte address
- vme_dat_reg_in  in  32  write data, [15:0] used
- vme_dat_reg_out  out  32  result: {16'h0,read data}, or 32'hDEADDEAD on timeout
- vme_dat_wr  out  1  one-cycle result strobe
- vme_addr  out  23  VME A[23:1]
- vme_write_n  out  1  low = write cycle
- vme_as_n  out  1  address strobe
- vme_ds_n  out  1  data strobe
- vme_data_out  out  16  write data
- vme_data_oe  out  1  data bus drive enable
- vme_data_in  in  16  read data
- vme_dtack_n  in  1  asynchronous DTACK
- err_cnt  out  16  timeout counter (see Optional Feature)

Behaviour:
- Reset values: vme_cmd_rd=0, vme_dat_wr=0, vme_dat_reg_out=0, vme_addr=0, vme_write_n=1, vme_as_n=1, vme_ds_n=1, vme_data_out=0, vme_data_oe=0, err_cnt=0. The FSM enters REQ.
- Reset asserted mid-cycle forces these values immediately, releasing AS/DS.
- vme_dtack_n passes through a 2-flop synchronizer. "DTACK low/high" below means the synchronized value.
- REQ: drive vme_cmd_rd=1 for exactly one clock, then go to CAPWAIT.
- CAPWAIT: one clock. The command inputs are sampled on the 2nd rising edge after the edge that raised vme_cmd_rd. The producer updates one edge late, so this sample is mandatory.
- DECODE:
  - If start=0: no-op. Wait POLL_GAP clocks, then REQ. No vme_dat_wr.
  - Else latch rd=cmd[25], addr=cmd[23:1], wdata=dat[15:0].
- ADDR: vme_addr=addr, vme_write_n=rd, vme_as_n=0. If write, vme_data_out=wdata and vme_data_oe=1. Hold ADDR_SETUP clocks.
- DS: vme_ds_n=0. Wait for DTACK low.
  - On DTACK low: if rd, capture vme_data_in that same edge. Go to RELEASE.
  - If the counter reaches DTACK_TIMEOUT: go to ABORT.
- RELEASE: vme_as_n=vme_ds_n=1, vme_data_oe=0 on the next edge. Wait for DTACK high, with a fresh timeout; expiry goes to ABORT.
- ABORT: same release of AS/DS/OE. Result=32'hDEADDEAD. Go to REPORT without waiting for DTACK.
- REPORT:
  - Load vme_dat_reg_out (read: {16'h0,data}; write: 32'h0; abort: 32'hDEADDEAD).
  - Assert vme_dat_wr for one clock in the following cycle.
  - vme_dat_reg_out holds until the next REPORT.
  - Then REQ.
- Timeout counter: 8-bit, clears on every state entry, counts one per clock in DS/RELEASE. Exact expiry occurs after DTACK_TIMEOUT clocks.
- DTACK already low on DS entry is accepted immediately (no edge requirement).
- Only one command is ever outstanding. vme_cmd_rd is never asserted between DECODE and REPORT.
- Nominal write latency with DTACK returning in 3 clocks: REQ to vme_dat_wr = 2+1+ADDR_SETUP+3+2(sync)+release+1.

Optional Feature:
- Macro VME_EXEC_ERRCNT_EN.
- Defined: err_cnt increments by 1 on each ABORT, saturates at 16'hFFFF, and clears only on reset.
- Undefined: err_cnt is tied to 16'h0 and no counter logic is built.
- The FSM is identical in both cases.

Test Plan:
- Write: start=1, cmd=32'h0000_3000 (bit25=0), dat=32'h0000_A5A5, DTACK low 3 clocks after DS_N. Expect:
  - vme_addr=23'h1800, write_n=0, data_out=16'hA5A5, oe=1.
  - AS_N low ≥2 clocks before DS_N.
  - vme_dat_wr pulse with vme_dat_reg_out=32'h0.
- Read: cmd=32'h0200_4100, slave returns 16'h1234. Expect write_n=1, oe=0, vme_dat_reg_out=32'h0000_1234 at the vme_dat_wr pulse.
- No-op: start=0 with cmd=32'h00F8_0000. Expect no AS_N activity, no vme_dat_wr, next vme_cmd_rd exactly POLL_GAP+3 clocks later.
- Timeout: DTACK held high. Expect:
  - DS_N/AS_N release after 255 clocks in DS.
  - vme_dat_reg_out=32'hDEADDEAD.
  - err_cnt=1 with VME_EXEC_ERRCNT_EN, 0 without.
- Reset mid-cycle: assert rst_n=0 while DS_N low. Expect AS_N=DS_N=1 and oe=0 asynchronously; after release, the first vme_cmd_rd pulse on the 1st clock.
- Back-to-back: 3 writes then 1 read. Expect exactly 4 vme_dat_wr pulses in order, and vme_cmd_rd never high while AS_N is low.

Source files
------------

// File: rtl/vme_cmd_executor_if.sv
// Command-file handshake and A24/D16 VME master bus bundle for vme_cmd_executor.
// The master modport is the executor; the slave modport is the command producer plus VME slave.
interface vme_cmd_executor_if;
  logic        vme_cmd_rd;
  logic        start;
  logic [31:0] vme_cmd_reg;
  logic [31:0] vme_dat_reg_in;
  logic [31:0] vme_dat_reg_out;
  logic        vme_dat_wr;
  logic [22:0] vme_addr;
  logic        vme_write_n;
  logic        vme_as_n;
  logic        vme_ds_n;
  logic [15:0] vme_data_out;
  logic        vme_data_oe;
  logic [15:0] vme_data_in;
  logic        vme_dtack_n;
  logic [15:0] err_cnt;

  modport master (
    output vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
    output vme_addr, vme_write_n, vme_as_n, vme_ds_n, vme_data_out, vme_data_oe, err_cnt,
    input  start, vme_cmd_reg, vme_dat_reg_in, vme_data_in, vme_dtack_n
  );

  modport slave (
    input  vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
    input  vme_addr, vme_write_n, vme_as_n, vme_ds_n, vme_data_out, vme_data_oe, err_cnt,
    output start, vme_cmd_reg, vme_dat_reg_in, vme_data_in, vme_dtack_n
  );
endinterface

// File: rtl/vme_cmd_executor.sv
// Pulls one command per transaction and runs it as an A24/D16 VME master cycle; optional VME_EXEC_ERRCNT_EN counts aborts.
// Latency: REQ to vme_dat_wr = 3 + ADDR_SETUP + DTACK delay + 2 sync + release wait + 1 clocks.
// Backpressure: one command outstanding; the next vme_cmd_rd is issued only after REPORT or the idle gap.
module vme_cmd_executor #(
  parameter int ADDR_SETUP    = 2,
  parameter int DTACK_TIMEOUT = 255,
  parameter int POLL_GAP      = 4
) (
  input logic               clk,
  input logic               rst_n,
  vme_cmd_executor_if.master bus
);

  typedef enum logic [3:0] {
    S_REQ, S_CAPWAIT, S_DECODE, S_GAP, S_ADDR, S_DS, S_RELEASE, S_ABORT, S_REPORT
  } state_t;

  localparam logic [7:0] GAP_LAST   = 8'(POLL_GAP - 1);
  localparam logic [7:0] SETUP_LAST = 8'(ADDR_SETUP - 1);
  localparam logic [7:0] TO_LAST    = 8'(DTACK_TIMEOUT - 1);

  state_t      state, next;
  logic [7:0]  cnt;
  logic        dtack_meta, dtack_s;
  logic        rd_q, aborted;
  logic [15:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{bus.vme_cmd_reg[31:26], bus.vme_cmd_reg[24], bus.vme_cmd_reg[0],
                         bus.vme_dat_reg_in[31:16]};

  // DTACK is asynchronous to clk; only dtack_s is used by the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtack_meta <= 1'b1;
      dtack_s    <= 1'b1;
    end else begin
      dtack_meta <= bus.vme_dtack_n;
      dtack_s    <= dtack_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_REQ:     next = S_CAPWAIT;
      S_CAPWAIT: next = S_DECODE;
      S_DECODE:  next = bus.start ? S_ADDR : S_GAP;
      S_GAP:     if (cnt == GAP_LAST) next = S_REQ;
      S_ADDR:    if (cnt == SETUP_LAST) next = S_DS;
      S_DS: begin
        if (!dtack_s)            next = S_RELEASE;
        else if (cnt == TO_LAST) next = S_ABORT;
      end
      S_RELEASE: begin
        if (dtack_s)             next = S_REPORT;
        else if (cnt == TO_LAST) next = S_ABORT;
      end
      S_ABORT:   next = S_REPORT;
      S_REPORT:  next = S_REQ;
      default:   next = S_REQ;
    endcase
  end

  // Shared timer: cleared on every state change, so each wait gets a fresh count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= 8'd0;
    else if (next != state) cnt <= 8'd0;
    else                    cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vme_cmd_rd      <= 1'b0;
      bus.vme_dat_wr      <= 1'b0;
      bus.vme_dat_reg_out <= 32'h0;
      bus.vme_addr        <= 23'h0;
      bus.vme_write_n     <= 1'b1;
      bus.vme_as_n        <= 1'b1;
      bus.vme_ds_n        <= 1'b1;
      bus.vme_data_out    <= 16'h0;
      bus.vme_data_oe     <= 1'b0;
      rd_q                <= 1'b0;
      aborted             <= 1'b0;
      rdata               <= 16'h0;
    end else begin
      bus.vme_cmd_rd <= (state == S_REQ);
      bus.vme_dat_wr <= (state == S_REPORT);
      if (state == S_DECODE && bus.start) begin
        rd_q             <= bus.vme_cmd_reg[25];
        aborted          <= 1'b0;
        bus.vme_addr     <= bus.vme_cmd_reg[23:1];
        bus.vme_write_n  <= bus.vme_cmd_reg[25];
        bus.vme_as_n     <= 1'b0;
        bus.vme_data_out <= bus.vme_cmd_reg[25] ? 16'h0 : bus.vme_dat_reg_in[15:0];
        bus.vme_data_oe  <= !bus.vme_cmd_reg[25];
      end
      if (state == S_ADDR && next == S_DS)
        bus.vme_ds_n <= 1'b0;
      if (state == S_DS && next == S_RELEASE && rd_q)
        rdata <= bus.vme_data_in;
      // Strobes drop on the same edge that DTACK is seen or the timeout fires
      if ((state == S_DS && next == S_RELEASE) || (state != S_ABORT && next == S_ABORT)) begin
        bus.vme_as_n    <= 1'b1;
        bus.vme_ds_n    <= 1'b1;
        bus.vme_data_oe <= 1'b0;
      end
      if (next == S_ABORT)
        aborted <= 1'b1;
      if (state == S_REPORT)
        bus.vme_dat_reg_out <= aborted ? 32'hDEADDEAD : (rd_q ? {16'h0, rdata} : 32'h0);
    end
  end

`ifdef VME_EXEC_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 16'h0;
    else if (state != S_ABORT && next == S_ABORT && err_q != 16'hFFFF)
      err_q <= err_q + 16'h1;
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_vme_cmd_executor.sv
// Randomized scoreboard bench for vme_cmd_executor: a producer/VME-slave model feeds commands,
// a monitor pops expected results and bus fields as the DUT presents them.
module tb_vme_cmd_executor;
  localparam int ADDR_SETUP    = 2;
  localparam int DTACK_TIMEOUT = 255;
  localparam int POLL_GAP      = 4;

  typedef struct {
    logic        start;
    logic [31:0] cmd;
    logic [31:0] dat;
    int          delay;
    logic        hang;
    logic [15:0] rdata;
  } txn_t;

  logic clk;
  logic rst_n;
  vme_cmd_executor_if bus();

  vme_cmd_executor #(.ADDR_SETUP(ADDR_SETUP), .DTACK_TIMEOUT(DTACK_TIMEOUT), .POLL_GAP(POLL_GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_pulses = 0;
  int rd_viol   = 0;

  txn_t        plan[$];
  txn_t        slave_q[$];
  txn_t        addr_q[$];
  logic [31:0] exp_q[$];

  logic have_last = 1'b0;
  logic last_was_noop = 1'b0;
  int   last_rd_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: what the command file should get back for an executed command
  function automatic logic [31:0] expect_result(input txn_t t);
    if (t.hang)        return 32'hDEADDEAD;
    else if (t.cmd[25]) return {16'h0, t.rdata};
    else               return 32'h0;
  endfunction

  function automatic txn_t mk(input logic start, input logic [31:0] cmd, input logic [31:0] dat,
                              input int delay, input logic hang, input logic [15:0] rdata);
    txn_t t;
    t.start = start; t.cmd = cmd; t.dat = dat; t.delay = delay; t.hang = hang; t.rdata = rdata;
    return t;
  endfunction

  // Producer: updates its command one edge late and scribbles garbage afterwards
  initial begin
    txn_t t;
    bus.start = 1'b0;
    bus.vme_cmd_reg = 32'h0;
    bus.vme_dat_reg_in = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.vme_cmd_rd) begin
        if (have_last && last_was_noop)
          check("noop_poll_gap", cyc - last_rd_cyc, POLL_GAP + 3);
        last_rd_cyc = cyc;
        have_last = 1'b1;
        @(posedge clk); #1;
        if (plan.size() > 0) t = plan.pop_front();
        else t = mk(1'b0, 32'h00F8_0000, 32'h0, 0, 1'b0, 16'h0);
        bus.start = t.start;
        bus.vme_cmd_reg = t.cmd;
        bus.vme_dat_reg_in = t.dat;
        last_was_noop = !t.start;
        if (t.start) begin
          slave_q.push_back(t);
          addr_q.push_back(t);
          exp_q.push_back(expect_result(t));
        end
        @(posedge clk); #1;
        bus.start = 1'($urandom);
        bus.vme_cmd_reg = $urandom;
        bus.vme_dat_reg_in = $urandom;
      end
    end
  end

  // VME slave: DTACK after t.delay clocks, released 0-2 clocks after DS_N rises
  initial begin
    txn_t t;
    int mode = 0;
    int cnt  = 0;
    bus.vme_dtack_n = 1'b1;
    bus.vme_data_in = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mode = 0;
        bus.vme_dtack_n = 1'b1;
      end else begin
        case (mode)
          0: if (!bus.vme_ds_n) begin
               if (slave_q.size() == 0) begin
                 n_tests++; n_fail++;
                 $display("FAIL slave_ds_unexpected: DS_N low with no command outstanding");
                 mode = 4;
               end else begin
                 t = slave_q.pop_front();
                 cnt = t.delay;
                 mode = t.hang ? 4 : 1;
               end
             end
          1: if (cnt <= 1) begin
               bus.vme_dtack_n = 1'b0;
               bus.vme_data_in = t.rdata;
               mode = 2;
             end else cnt--;
          2: if (bus.vme_ds_n) begin
               cnt = $urandom_range(0, 2);
               if (cnt == 0) begin
                 bus.vme_dtack_n = 1'b1;
                 bus.vme_data_in = 16'($urandom);
                 mode = 0;
               end else mode = 3;
             end
          3: begin
               cnt--;
               if (cnt == 0) begin
                 bus.vme_dtack_n = 1'b1;
                 bus.vme_data_in = 16'($urandom);
                 mode = 0;
               end
             end
          default: if (bus.vme_ds_n) mode = 0;
        endcase
      end
    end
  end

  // Monitor: results, bus fields at DS_N fall, strobe timing
  initial begin
    txn_t cur;
    logic prev_ds = 1'b1;
    int   as_cnt = 0;
    int   ds_cnt = 0;
    cur = mk(1'b0, 32'h0, 32'h0, 0, 1'b0, 16'h0);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ds = 1'b1; as_cnt = 0; ds_cnt = 0;
      end else begin
        if (bus.vme_dat_wr) begin
          wr_pulses++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL dat_wr_unexpected: pulse with reg_out %h, required no pulse", bus.vme_dat_reg_out);
          end else check("result", bus.vme_dat_reg_out, exp_q.pop_front());
        end
        if (bus.vme_cmd_rd && !bus.vme_as_n) rd_viol++;
        as_cnt = bus.vme_as_n ? 0 : as_cnt + 1;
        if (!bus.vme_ds_n && prev_ds) begin
          if (addr_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL ds_unexpected: DS_N fell with no command, required none");
          end else begin
            cur = addr_q.pop_front();
            check("vme_addr", {9'h0, bus.vme_addr}, {9'h0, cur.cmd[23:1]});
            check("vme_write_n", {31'h0, bus.vme_write_n}, {31'h0, cur.cmd[25]});
            check("vme_data_oe", {31'h0, bus.vme_data_oe}, {31'h0, !cur.cmd[25]});
            if (!cur.cmd[25]) check("vme_data_out", {16'h0, bus.vme_data_out}, {16'h0, cur.dat[15:0]});
            check("as_setup_ge", {31'h0, (as_cnt - 1) >= ADDR_SETUP}, 32'h1);
          end
          ds_cnt = 0;
        end
        if (!bus.vme_ds_n) ds_cnt++;
        if (bus.vme_ds_n && !prev_ds && cur.hang) begin
          check("timeout_ds_len", ds_cnt, DTACK_TIMEOUT);
          check("timeout_as_release", {31'h0, bus.vme_as_n}, 32'h1);
        end
        prev_ds = bus.vme_ds_n;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((plan.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_budget", plan.size() + exp_q.size(), 0);
  endtask

  initial begin
    int base;
    logic [15:0] exp_err;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rd", {31'h0, bus.vme_cmd_rd}, 32'h0);
    check("rst_dat_wr", {31'h0, bus.vme_dat_wr}, 32'h0);
    check("rst_reg_out", bus.vme_dat_reg_out, 32'h0);
    check("rst_addr", {9'h0, bus.vme_addr}, 32'h0);
    check("rst_strobes", {28'h0, bus.vme_write_n, bus.vme_as_n, bus.vme_ds_n, bus.vme_data_oe}, 32'hE);
    check("rst_data_out", {16'h0, bus.vme_data_out}, 32'h0);
    check("rst_err_cnt", {16'h0, bus.err_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    plan.push_back(mk(1'b1, 32'h0000_3000, 32'h0000_A5A5, 3, 1'b0, 16'h0));
    plan.push_back(mk(1'b1, 32'h0200_4100, 32'h0, 3, 1'b0, 16'h1234));
    plan.push_back(mk(1'b0, 32'h00F8_0000, 32'h0, 0, 1'b0, 16'h0));
    wait_drain(400);

    plan.push_back(mk(1'b1, 32'h0012_3456, 32'h0000_5A5A, 0, 1'b1, 16'h0));
    wait_drain(1500);
`ifdef VME_EXEC_ERRCNT_EN
    exp_err = 16'h1;
`else
    exp_err = 16'h0;
`endif
    check("err_cnt_after_timeout", {16'h0, bus.err_cnt}, {16'h0, exp_err});

    base = wr_pulses;
    for (int i = 0; i < 3; i++)
      plan.push_back(mk(1'b1, $urandom & 32'hFDFF_FFFF, $urandom, $urandom_range(1, 4), 1'b0, 16'h0));
    plan.push_back(mk(1'b1, $urandom | 32'h0200_0000, 32'h0, 2, 1'b0, 16'($urandom)));
    wait_drain(600);
    check("b2b_pulses", wr_pulses - base, 4);

    for (int i = 0; i < 40; i++)
      plan.push_back(mk($urandom_range(0, 4) != 0, $urandom, $urandom, $urandom_range(0, 6), 1'b0, 16'($urandom)));
    wait_drain(4000);

    plan.push_back(mk(1'b1, 32'h0000_0100, 32'h0000_1111, 0, 1'b1, 16'h0));
    for (int i = 0; i < 300 && bus.vme_ds_n; i++) @(posedge clk);
    check("reset_ds_low_seen", {31'h0, bus.vme_ds_n}, 32'h0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_strobes", {29'h0, bus.vme_as_n, bus.vme_ds_n, bus.vme_data_oe}, 32'h6);
    plan.delete(); slave_q.delete(); addr_q.delete(); exp_q.delete();
    have_last = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_rd_after_reset", {31'h0, bus.vme_cmd_rd}, 32'h1);
    check("err_cnt_after_reset", {16'h0, bus.err_cnt}, 32'h0);
    repeat (20) @(posedge clk);

    check("cmd_rd_during_as", rd_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
